// File: rtl/bsc_ompss_addr_interleaver_pipe.sv
// Generic register-based FIFO used as the skid buffer of the interleaver.
// Latency: a word written at edge N is readable after edge N (no bypass).
// Backpressure: wr_rdy is a register (count_next < DEPTH), no path from rd_rdy.
module bsc_ompss_aip_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_vld,
   output logic             wr_rdy,
   input  logic [WIDTH-1:0] wr_dat,
   output logic             rd_vld,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic [PW:0]      count_next;
   logic             push;
   logic             pop;

   assign push   = wr_vld & wr_rdy;
   assign pop    = rd_vld & rd_rdy;
   assign rd_vld = (count != '0);
   assign rd_dat = mem[rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + (PW+1)'(1);
      end else if (!push && pop) begin
         count_next = count - (PW+1)'(1);
      end
   end

   // Storage, pointers, occupancy and the registered ready flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         wr_rdy <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         count  <= count_next;
         wr_rdy <= (count_next < (PW+1)'(DEPTH));
      end
   end

endmodule

// DDR address interleaver: rotates stride-sized chunks across banks inside the DDR window.
// Latency: beat accepted at edge N is presented after edge N through a 2-entry skid buffer.
// Backpressure: s_ready is registered, low only when both skid entries are occupied.
module bsc_ompss_addr_interleaver_pipe #(
   parameter int unsigned            ADDR_WIDTH      = 64,
   parameter int unsigned            USER_WIDTH      = 8,
   parameter int unsigned            NUM_BANKS       = 4,
   parameter int unsigned            BANK_SIZE_LOG2  = 34,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR       = '0,
   parameter int unsigned            STRIDE_LOG2_RST = 13,
   parameter int unsigned            CNT_WIDTH       = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cfg_enable,
   input  logic [5:0]            cfg_stride_log2,
   input  logic                  cfg_load,
   output logic                  cfg_err,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [ADDR_WIDTH-1:0] s_addr,
   input  logic [USER_WIDTH-1:0] s_user,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [USER_WIDTH-1:0] m_user,
   output logic                  m_hit,
   output logic [3:0]            m_bank,
   input  logic [3:0]            cnt_sel,
   input  logic                  cnt_clr,
   output logic [CNT_WIDTH-1:0]  cnt_data
);

   localparam int unsigned NB  = $clog2(NUM_BANKS);
   localparam int unsigned NBW = (NB > 0) ? NB : 1;
   localparam int unsigned AIW = $clog2(ADDR_WIDTH);

   // Window bounds carried at ADDR_WIDTH+1 bits so a window ending exactly at
   // 2^ADDR_WIDTH does not wrap.
   localparam logic [ADDR_WIDTH:0] WIN_LO   = {1'b0, BASE_ADDR};
   localparam logic [ADDR_WIDTH:0] WIN_SPAN = (ADDR_WIDTH+1)'(NUM_BANKS) << BANK_SIZE_LOG2;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [USER_WIDTH-1:0] user;
      logic                  hit;
      logic [3:0]            bank;
   } beat_t;

   logic                  en_q;
   logic [5:0]            s_q;
   logic [6:0]            stride_end;
   logic                  stride_bad;

   logic [ADDR_WIDTH:0]   off_ext;
   logic [ADDR_WIDTH-1:0] off;
   logic [ADDR_WIDTH-1:0] remap_off;
   logic [NBW-1:0]        bank_idx;
   logic                  in_win;
   logic                  hit;
   beat_t                 in_beat;
   beat_t                 out_beat;

   logic [CNT_WIDTH-1:0]  cnt_q [NUM_BANKS];
   logic [CNT_WIDTH-1:0]  cnt_mux;
   logic                  out_hs;

   // ---------------------------------------------------------------- config
   // A stride is usable only if the bank-select field sits at bit 6 or above
   // and ends at or below the bank-size field it is swapped with.
   assign stride_end = {1'b0, cfg_stride_log2} + 7'(NB);
   assign stride_bad = (cfg_stride_log2 < 6'd6) || (stride_end > 7'(BANK_SIZE_LOG2));

   // Config registers; an illegal load disables interleaving but keeps the old stride.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         en_q    <= 1'b0;
         s_q     <= 6'(STRIDE_LOG2_RST);
         cfg_err <= 1'b0;
      end else if (cfg_load) begin
         if (stride_bad) begin
            en_q    <= 1'b0;
            cfg_err <= 1'b1;
         end else begin
            en_q <= cfg_enable;
            s_q  <= cfg_stride_log2;
         end
      end
   end

   // ----------------------------------------------------------------- remap
   // Offset from the window base; an address below the base borrows into the
   // top bit and therefore lands above WIN_SPAN, so one compare covers both ends.
   assign off_ext  = {1'b0, s_addr} - WIN_LO;
   assign off      = off_ext[ADDR_WIDTH-1:0];
   assign in_win   = (off_ext < WIN_SPAN);
   assign hit      = en_q && (NUM_BANKS > 1) && in_win;
   assign bank_idx = NBW'(off >> s_q);

   // Swap the stride-selected field with the bank field, bit by bit.
   always_comb begin
      logic [AIW-1:0] lo_pos;
      logic [AIW-1:0] hi_pos;
      remap_off = off;
      lo_pos    = '0;
      hi_pos    = '0;
      for (int i = 0; i < int'(NB); i++) begin
         lo_pos            = AIW'(s_q) + AIW'(i);
         hi_pos            = AIW'(BANK_SIZE_LOG2 + i);
         remap_off[lo_pos] = off[hi_pos];
         remap_off[hi_pos] = off[lo_pos];
      end
   end

   // Beat as it will be stored in the skid buffer.
   always_comb begin
      in_beat      = '0;
      in_beat.user = s_user;
      in_beat.hit  = hit;
      if (hit) begin
         in_beat.addr = BASE_ADDR + remap_off;
         in_beat.bank = 4'(bank_idx);
      end else begin
         in_beat.addr = s_addr;
         in_beat.bank = 4'd0;
      end
   end

   // ----------------------------------------------------------- skid buffer
   bsc_ompss_aip_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (2)
   ) u_skid (
      .clk    (aclk),
      .rst_n  (aresetn),
      .wr_vld (s_valid),
      .wr_rdy (s_ready),
      .wr_dat (in_beat),
      .rd_vld (m_valid),
      .rd_rdy (m_ready),
      .rd_dat (out_beat)
   );

   assign m_addr = out_beat.addr;
   assign m_user = out_beat.user;
   assign m_hit  = out_beat.hit;
   assign m_bank = out_beat.bank;

   // -------------------------------------------------------------- counters
   assign out_hs = m_valid & m_ready & m_hit;

   // Per-bank saturating hit counters; a clear beats a same-cycle increment.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int b = 0; b < int'(NUM_BANKS); b++) begin
            cnt_q[b] <= '0;
         end
      end else if (cnt_clr) begin
         for (int b = 0; b < int'(NUM_BANKS); b++) begin
            cnt_q[b] <= '0;
         end
      end else if (out_hs) begin
         for (int b = 0; b < int'(NUM_BANKS); b++) begin
            if ((m_bank == 4'(b)) && (cnt_q[b] != '1)) begin
               cnt_q[b] <= cnt_q[b] + CNT_WIDTH'(1);
            end
         end
      end
   end

   // Counter read mux; selects beyond the bank count read as zero.
   always_comb begin
      cnt_mux = '0;
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
         if (cnt_sel == 4'(b)) begin
            cnt_mux = cnt_q[b];
         end
      end
   end

   // Registered counter read-back.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_data <= '0;
      end else begin
         cnt_data <= cnt_mux;
      end
   end

endmodule

// File: tb/tb_bsc_ompss_addr_interleaver_pipe.sv
// Testbench for the pipelined DDR address interleaver.
// Scoreboard: expected beats queued at input acceptance, monitor pops on output handshake.
// Drives backpressure, illegal config, counters, mid-stream reset and random traffic.
module tb_bsc_ompss_addr_interleaver_pipe;

   localparam int NBK = 4;
   localparam int BL  = 34;
   localparam int CW  = 32;

   logic          aclk = 1'b0;
   logic          aresetn;
   logic          cfg_enable;
   logic [5:0]    cfg_stride_log2;
   logic          cfg_load;
   logic          cfg_err;
   logic          s_valid;
   logic          s_ready;
   logic [63:0]   s_addr;
   logic [7:0]    s_user;
   logic          m_valid;
   logic          m_ready;
   logic [63:0]   m_addr;
   logic [7:0]    m_user;
   logic          m_hit;
   logic [3:0]    m_bank;
   logic [3:0]    cnt_sel;
   logic          cnt_clr;
   logic [CW-1:0] cnt_data;

   always #5 aclk = ~aclk;

   bsc_ompss_addr_interleaver_pipe #(
      .ADDR_WIDTH      (64),
      .USER_WIDTH      (8),
      .NUM_BANKS       (NBK),
      .BANK_SIZE_LOG2  (BL),
      .BASE_ADDR       (64'h0),
      .STRIDE_LOG2_RST (13),
      .CNT_WIDTH       (CW)
   ) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .cfg_enable      (cfg_enable),
      .cfg_stride_log2 (cfg_stride_log2),
      .cfg_load        (cfg_load),
      .cfg_err         (cfg_err),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_addr          (s_addr),
      .s_user          (s_user),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .m_addr          (m_addr),
      .m_user          (m_user),
      .m_hit           (m_hit),
      .m_bank          (m_bank),
      .cnt_sel         (cnt_sel),
      .cnt_clr         (cnt_clr),
      .cnt_data        (cnt_data)
   );

   typedef struct {
      logic [63:0] addr;
      logic [7:0]  user;
      logic        hit;
      logic [3:0]  bank;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference state: config registers and per-bank counters.
   logic        mdl_en;
   int          mdl_s;
   logic        mdl_err;
   logic [31:0] mdl_cnt [NBK];
   logic        rnd_done;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      mdl_en  = 1'b0;
      mdl_s   = 13;
      mdl_err = 1'b0;
      for (int b = 0; b < NBK; b++) mdl_cnt[b] = '0;
   endtask

   // Address interleaving expressed arithmetically: subtract both fields out
   // of the offset and add them back in each other's position.
   function automatic exp_t predict(input logic [63:0] a, input logic [7:0] u);
      exp_t        e;
      logic [63:0] win;
      logic [63:0] lo_f;
      logic [63:0] hi_f;
      win    = 64'(NBK) << BL;
      e.user = u;
      if (mdl_en && (a < win)) begin
         lo_f   = (a >> mdl_s) % 64'(NBK);
         hi_f   = (a >> BL) % 64'(NBK);
         e.addr = a - (lo_f << mdl_s) - (hi_f << BL) + (hi_f << mdl_s) + (lo_f << BL);
         e.hit  = 1'b1;
         e.bank = 4'(lo_f);
      end else begin
         e.addr = a;
         e.hit  = 1'b0;
         e.bank = 4'd0;
      end
      return e;
   endfunction

   // Present one beat; the expectation is queued on the cycle it is accepted.
   task automatic send(input logic [63:0] a, input logic [7:0] u);
      int waited;
      s_valid = 1'b1;
      s_addr  = a;
      s_user  = u;
      waited  = 0;
      @(negedge aclk);
      while (!s_ready && waited < 300) begin
         waited++;
         @(negedge aclk);
      end
      if (!s_ready) begin
         check("send_timeout_s_ready", s_ready, 1);
         @(posedge aclk);
         #1;
         s_valid = 1'b0;
      end else begin
         exp_q.push_back(predict(a, u));
         @(posedge aclk);
         #1;
         s_valid = 1'b0;
      end
   endtask

   task automatic do_cfg(input logic en, input int st);
      cfg_enable      = en;
      cfg_stride_log2 = 6'(st);
      cfg_load        = 1'b1;
      @(posedge aclk);
      #1;
      cfg_load = 1'b0;
      if (st < 6 || st + 2 > BL) begin
         mdl_en  = 1'b0;
         mdl_err = 1'b1;
      end else begin
         mdl_en = en;
         mdl_s  = st;
      end
      check("cfg_err", cfg_err, mdl_err);
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 500) begin
         @(posedge aclk);
         waited++;
      end
      check("drain_queue_empty", 64'(exp_q.size()), 0);
      @(posedge aclk);
      #1;
   endtask

   task automatic check_cnt(input int sel);
      cnt_sel = 4'(sel);
      @(posedge aclk);
      #1;
      check($sformatf("cnt_data[%0d]", sel), cnt_data, (sel < NBK) ? 64'(mdl_cnt[sel]) : 64'd0);
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      logic [63:0] win;
      win = 64'(NBK) << BL;
      a   = (64'($urandom) << 32) | 64'($urandom);
      case ($urandom_range(0, 3))
         0, 1:    a = a % win;
         2:       a = win - 64'($urandom_range(0, 64));
         default: a = a;
      endcase
      return a;
   endfunction

   // Output monitor: pops the scoreboard on every handshake, checks that a
   // stalled beat stays put, and tracks the counters the DUT should hold.
   initial begin
      logic        pend;
      logic [63:0] pend_addr;
      logic [7:0]  pend_user;
      logic        hs;
      exp_t        e;
      pend = 1'b0;
      pend_addr = '0;
      pend_user = '0;
      forever begin
         @(negedge aclk);
         if (aresetn !== 1'b1) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               check("stall_m_valid", m_valid, 1);
               check("stall_m_addr", m_addr, pend_addr);
               check("stall_m_user", m_user, pend_user);
            end
            hs = m_valid && m_ready;
            e.hit = 1'b0;
            e.bank = '0;
            if (hs) begin
               if (exp_q.size() == 0) begin
                  check("spurious_beat_queue_size", 0, 1);
               end else begin
                  e = exp_q.pop_front();
                  check("m_addr", m_addr, e.addr);
                  check("m_user", m_user, e.user);
                  check("m_hit", m_hit, e.hit);
                  check("m_bank", m_bank, e.bank);
               end
            end
            if (cnt_clr) begin
               for (int b = 0; b < NBK; b++) mdl_cnt[b] = '0;
            end else if (hs && e.hit) begin
               if (mdl_cnt[int'(e.bank)] != '1) mdl_cnt[int'(e.bank)]++;
            end
            pend      = m_valid && !m_ready;
            pend_addr = m_addr;
            pend_user = m_user;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn         = 1'b0;
      cfg_enable      = 1'b0;
      cfg_stride_log2 = '0;
      cfg_load        = 1'b0;
      s_valid         = 1'b0;
      s_addr          = '0;
      s_user          = '0;
      m_ready         = 1'b1;
      cnt_sel         = '0;
      cnt_clr         = 1'b0;
      rnd_done        = 1'b0;
      model_reset();

      // Reset state.
      #2;
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_user", m_user, 0);
      check("rst_m_hit", m_hit, 0);
      check("rst_m_bank", m_bank, 0);
      check("rst_cnt_data", cnt_data, 0);
      check("rst_cfg_err", cfg_err, 0);
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("s_ready_after_release", s_ready, 1);

      // Basic remap with the default stride.
      do_cfg(1'b1, 13);
      send(64'h2000, 8'h01);
      send(64'h6000, 8'h02);
      send(64'h4_0000_0000, 8'h03);
      send(64'h0_0000_1234, 8'h04);
      drain();

      // Just past the window end passes through.
      send(64'h10_0000_0000, 8'h05);
      drain();
      for (int b = 0; b < NBK; b++) check_cnt(b);

      // Backpressure: two beats fill the buffer, a third must wait.
      m_ready = 1'b0;
      send(64'h0_0000_A000, 8'h11);
      send(64'h1_2345_6000, 8'h22);
      check("full_s_ready", s_ready, 0);
      fork
         send(64'h20_0000_0000, 8'h33);
      join_none
      repeat (3) @(posedge aclk);
      #1;
      check("full_s_ready_held", s_ready, 0);
      m_ready = 1'b1;
      wait fork;
      drain();

      // Illegal stride disables interleaving and latches the error.
      do_cfg(1'b1, 33);
      send(64'h2000, 8'h44);
      drain();

      // Counters: five hits to bank 2, then clear racing a bank-2 handshake.
      do_cfg(1'b1, 13);
      cnt_clr = 1'b1;
      @(posedge aclk);
      #1;
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) send(64'h4000 | 64'($urandom_range(0, 16'h1fff)), 8'($urandom));
      drain();
      check_cnt(2);
      check_cnt(1);
      check_cnt(5);
      m_ready = 1'b0;
      send(64'h4000, 8'h55);
      m_ready = 1'b1;
      cnt_clr = 1'b1;
      @(posedge aclk);
      #1;
      cnt_clr = 1'b0;
      drain();
      check_cnt(2);

      // Random traffic with random backpressure and occasional reconfiguration.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if (i % 25 == 0) do_cfg($urandom_range(0, 3) != 0, $urandom_range(0, 40));
               send(rand_addr(), 8'($urandom));
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge aclk);
               #1;
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join
      drain();
      for (int b = 0; b <= NBK; b++) check_cnt(b);

      // Reset in the middle of a stalled transfer.
      do_cfg(1'b1, 13);
      m_ready = 1'b0;
      send(64'h2000, 8'h66);
      send(64'h6000, 8'h77);
      aresetn = 1'b0;
      #1;
      check("midrst_m_valid", m_valid, 0);
      check("midrst_s_ready", s_ready, 0);
      check("midrst_cfg_err", cfg_err, 0);
      check("midrst_cnt_data", cnt_data, 0);
      exp_q.delete();
      model_reset();
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      m_ready = 1'b1;
      @(posedge aclk);
      #1;
      check("midrst_s_ready_after", s_ready, 1);
      for (int b = 0; b < NBK; b++) check_cnt(b);
      send(64'h2000, 8'h88);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
